io_port_controller: RTL and testbench
=====================================

# io_port_controller

Sequences the SAP-2 IN/OUT instructions against the four external ports: input ports 01h (keyboard) and 02h (serial in), output ports 03h (parallel out) and 04h (serial out). It sits between the controller/sequencer and the port hardware. It freezes the T-state ring counter while a port handshake is pending, then moves the byte between the accumulator and the port. One transfer runs at a time, with a bounded wait per handshake.

## Interface
- TIMEOUT, 255: maximum cycles spent in any wait state before the transfer aborts (1..255).
- inCLK  in  1  system clock, rising edge.
- inRST  in  1  reset, asynchronous, active-high.
- iInReq  in  1  controller is executing IN byte; a one-cycle pulse.
- iOutReq  in  1  controller is executing OUT byte; a one-cycle pulse.
- iPortAddr  in  8  port operand byte, valid with the request.
- iAccData  in  8  accumulator value, valid with iOutReq.
- iP1Ready, iP2Ready  in  1 each  input port has data.
- iP1Data, iP2Data  in  8 each  input port data.
- iP3Busy, iP4Busy  in  1 each  output port cannot accept data.
- oP1Ack, oP2Ack  out  1 each  input acknowledge.
- oP3Data, oP4Data  out  8 each  registered output port latches.
- oP3Strobe, oP4Strobe  out  1 each  one-cycle "data valid" strobe.
- oBusData  out  8  byte for the W-bus, for the accumulator load.
- oLoadA  out  1  one-cycle accumulator load strobe.
- oStall  out  1  hold the ring counter.
- oDone  out  1  one-cycle transfer complete.
- oErr  out  1  one-cycle error, coincident with oDone.

## Operation
- States: IDLE, IN_WAIT, IN_ACK, IN_REL, OUT_WAIT, OUT_STB, DONE.
- IDLE, iInReq=1:
  - port 01h/02h → IN_WAIT.
  - any other port → DONE with error; no load.
- IDLE, iOutReq=1:
  - port 03h/04h → OUT_WAIT; iAccData is captured into the pending register.
  - any other port → DONE with error; no latch update.
- IDLE, iInReq and iOutReq both 1: IN wins, and the cycle's outcome is forced to an error (oErr at DONE). The IN transfer still completes normally.
- Requests arriving in any state other than IDLE are ignored.
- IN_WAIT: when the selected iPnReady=1, capture iPnData into the data register and go to IN_ACK.
- IN_ACK, one cycle:
  - oPnAck=1, oLoadA=1, oBusData=captured byte.
  - → IN_REL.
- IN_REL: oPnAck stays 1 until iPnReady=0, then → DONE.
- OUT_WAIT: when the selected iPnBusy=0, copy the pending byte into oPnData and go to OUT_STB.
- OUT_STB, one cycle: oPnStrobe=1 → DONE. oPnData holds its value until the next OUT to the same port.
- DONE, one cycle: oDone=1, oErr as recorded → IDLE.
- Timeout counter (8 bits):
  - Cleared on entry to IN_WAIT, IN_REL and OUT_WAIT; increments each cycle spent there.
  - On reaching TIMEOUT: → DONE with oErr=1.
  - If the timeout hits in IN_WAIT, go through IN_ACK with byte 00h first (oLoadA=1, oBusData=00h, ack still pulsed). Then → DONE with error.
  - An OUT timeout leaves oPnData unchanged and issues no strobe.
- oStall = (state≠IDLE and state≠DONE) or (state=IDLE and a request is accepted this cycle). This is combinational so the ring counter freezes in the request cycle itself.
- oBusData = data register in every state; it is 00h out of reset.

## Timing
- Reset, asynchronous:
  - State returns to IDLE; data/pending registers, counter, oP3Data and oP4Data are cleared to 00h.
  - All strobes, acks, oStall, oDone and oErr are 0.
  - Reset mid-transfer abandons the transfer with no completion pulse.
- IN with ready already high: request at edge 0; IN_WAIT capture at edge 1; IN_ACK (oLoadA) in cycle 2; IN_REL. The minimum from request to oDone is 4 cycles if ready drops during IN_ACK.
- OUT with busy low: request at edge 0; OUT_WAIT → OUT_STB in cycle 2; oDone in cycle 3. oPnData updates at the edge entering OUT_STB.
- Invalid port: oDone/oErr appear in the cycle after the request, and oStall is 1 only in the request cycle.
- All outputs except oStall are registered or decoded from state alone.

## Test plan
- IN 01h, iP1Data=5Ah, iP1Ready=1, ready drops in the ack cycle → oLoadA pulse with oBusData=5Ah, one oP1Ack cycle, oDone 4 cycles after the request, oErr=0.
- OUT 04h, iAccData=C3h, iP4Busy=1 for 10 cycles → oStall is held throughout. Then oP4Data=C3h, a single oP4Strobe, oDone, and oP3Data stays 00h.
- IN 02h with iP2Ready stuck at 0 and TIMEOUT=8 → IN_ACK with oBusData=00h, then oDone and oErr together; oStall drops when DONE is reached.
- IN with port 07h, and separately simultaneous iInReq+iOutReq to port 01h with ready=1 → port 07h gives oDone+oErr with no oLoadA. The simultaneous case completes the IN and flags oErr; no OUT strobe occurs.
- inRST asserted during OUT_WAIT after oP3Data=11h → all outputs go to 0/00h immediately. The next OUT 03h with A=22h completes normally.
- A second iInReq issued while in IN_REL → ignored; exactly one oDone is seen.

Source files
------------

// File: rtl/io_port_controller.sv
// io_port_controller
//
// Sequences the SAP-2 IN/OUT instructions against four external ports:
//   01h keyboard in, 02h serial in, 03h parallel out, 04h serial out.
// While a port handshake is pending the T-state ring counter is frozen
// (oStall). One transfer runs at a time. Each wait state is bounded by
// TIMEOUT cycles, after which the transfer completes with an error.
//
// Ports
//   inCLK, inRST          clock (rising edge), async active-high reset
//   iInReq / iOutReq      one-cycle IN / OUT request pulses from the sequencer
//   iPortAddr, iAccData   port operand and accumulator value, valid with request
//   iP1Ready/iP2Ready     input port has data; iP1Data/iP2Data the data
//   iP3Busy/iP4Busy       output port cannot accept data
//   oP1Ack/oP2Ack         input port acknowledge
//   oP3Data/oP4Data       output port latches; oP3Strobe/oP4Strobe data valid
//   oBusData, oLoadA      byte and load strobe for the accumulator
//   oStall                hold the ring counter (combinational)
//   oDone, oErr           one-cycle completion and error pulses

module io_port_controller #(
  parameter int TIMEOUT = 255
) (
  input  logic       inCLK,
  input  logic       inRST,
  input  logic       iInReq,
  input  logic       iOutReq,
  input  logic [7:0] iPortAddr,
  input  logic [7:0] iAccData,
  input  logic       iP1Ready,
  input  logic       iP2Ready,
  input  logic [7:0] iP1Data,
  input  logic [7:0] iP2Data,
  input  logic       iP3Busy,
  input  logic       iP4Busy,
  output logic       oP1Ack,
  output logic       oP2Ack,
  output logic [7:0] oP3Data,
  output logic [7:0] oP4Data,
  output logic       oP3Strobe,
  output logic       oP4Strobe,
  output logic [7:0] oBusData,
  output logic       oLoadA,
  output logic       oStall,
  output logic       oDone,
  output logic       oErr
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_IN_WAIT  = 3'd1,
    S_IN_ACK   = 3'd2,
    S_IN_REL   = 3'd3,
    S_OUT_WAIT = 3'd4,
    S_OUT_STB  = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  // Last counter value allowed in a wait state: TIMEOUT cycles in total.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;     // byte presented on the W-bus
  logic [7:0] pend_q, pend_d;     // accumulator byte waiting for an output port
  logic [7:0] p3_q, p3_d;
  logic [7:0] p4_q, p4_d;
  logic       sel_q, sel_d;       // 0: port 01h/03h, 1: port 02h/04h
  logic       err_q, err_d;       // error to report at DONE
  logic       abort_q, abort_d;   // IN_WAIT timed out: skip IN_REL
  logic [1:0] ack_q, ack_d;       // {oP2Ack, oP1Ack}

  logic       in_ok, out_ok, ready_sel, busy_sel, tmo, req_any;
  logic [1:0] ack_sel;

  assign in_ok     = (iPortAddr == 8'h01) || (iPortAddr == 8'h02);
  assign out_ok    = (iPortAddr == 8'h03) || (iPortAddr == 8'h04);
  assign ready_sel = sel_q ? iP2Ready : iP1Ready;
  assign busy_sel  = sel_q ? iP4Busy : iP3Busy;
  assign tmo       = (cnt_q == TMO_LAST);
  assign req_any   = iInReq || iOutReq;
  assign ack_sel   = sel_q ? 2'b10 : 2'b01;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    pend_d  = pend_q;
    p3_d    = p3_q;
    p4_d    = p4_q;
    sel_d   = sel_q;
    err_d   = err_q;
    abort_d = abort_q;
    ack_d   = 2'b00;

    unique case (state_q)
      S_IDLE: begin
        cnt_d   = 8'd0;
        err_d   = 1'b0;
        abort_d = 1'b0;
        if (iInReq) begin
          // A simultaneous OUT request loses but is still flagged as an error.
          sel_d = (iPortAddr == 8'h02);
          err_d = iOutReq;
          if (in_ok) begin
            state_d = S_IN_WAIT;
          end else begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end else if (iOutReq) begin
          sel_d = (iPortAddr == 8'h04);
          if (out_ok) begin
            state_d = S_OUT_WAIT;
            pend_d  = iAccData;
          end else begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end

      S_IN_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (ready_sel) begin
          data_d  = sel_q ? iP2Data : iP1Data;
          state_d = S_IN_ACK;
          ack_d   = ack_sel;
        end else if (tmo) begin
          // Abort still walks through IN_ACK so the accumulator gets 00h.
          data_d  = 8'h00;
          err_d   = 1'b1;
          abort_d = 1'b1;
          state_d = S_IN_ACK;
          ack_d   = ack_sel;
        end
      end

      S_IN_ACK: begin
        cnt_d = 8'd0;
        if (abort_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_IN_REL;
          // Ack is registered: it follows ready with one cycle of delay.
          ack_d   = ready_sel ? ack_sel : 2'b00;
        end
      end

      S_IN_REL: begin
        cnt_d = cnt_q + 8'd1;
        if (!ready_sel) begin
          state_d = S_DONE;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          ack_d = ack_sel;
        end
      end

      S_OUT_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (!busy_sel) begin
          if (sel_q) p4_d = pend_q;
          else       p3_d = pend_q;
          state_d = S_OUT_STB;
        end else if (tmo) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_OUT_STB: state_d = S_DONE;

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge inCLK or posedge inRST) begin
    if (inRST) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      data_q  <= 8'd0;
      pend_q  <= 8'd0;
      p3_q    <= 8'd0;
      p4_q    <= 8'd0;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
      abort_q <= 1'b0;
      ack_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      p3_q    <= p3_d;
      p4_q    <= p4_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      abort_q <= abort_d;
      ack_q   <= ack_d;
    end
  end

  assign oP1Ack    = ack_q[0];
  assign oP2Ack    = ack_q[1];
  assign oP3Data   = p3_q;
  assign oP4Data   = p4_q;
  assign oP3Strobe = (state_q == S_OUT_STB) && !sel_q;
  assign oP4Strobe = (state_q == S_OUT_STB) && sel_q;
  assign oBusData  = data_q;
  assign oLoadA    = (state_q == S_IN_ACK);
  assign oDone     = (state_q == S_DONE);
  assign oErr      = (state_q == S_DONE) && err_q;
  // Combinational so the ring counter freezes in the request cycle itself.
  assign oStall    = ((state_q != S_IDLE) && (state_q != S_DONE)) ||
                     ((state_q == S_IDLE) && req_any);

endmodule

// File: tb/tb_io_port_controller.sv
// Testbench for io_port_controller. Two instances share the stimulus: one
// with a short timeout (8) and one with the default (255). Expected outputs
// for each cycle of a transaction are derived from the port timing rules
// (first-ready / first-not-busy search over the stimulus waveforms).
module tb_io_port_controller;

  localparam int TA   = 8;
  localparam int TB   = 255;
  localparam int MAXL = 600;

  typedef struct packed {
    logic       stall, load, ack1, ack2, stb3, stb4, done, err;
    logic [7:0] bus, p3, p4;
  } obs_t;

  logic       inCLK, inRST;
  logic       iInReq, iOutReq;
  logic [7:0] iPortAddr, iAccData, iP1Data, iP2Data;
  logic       iP1Ready, iP2Ready, iP3Busy, iP4Busy;

  logic       a_ack1, a_ack2, a_stb3, a_stb4, a_load, a_stall, a_done, a_err;
  logic [7:0] a_p3, a_p4, a_bus;
  logic       b_ack1, b_ack2, b_stb3, b_stb4, b_load, b_stall, b_done, b_err;
  logic [7:0] b_p3, b_p4, b_bus;

  io_port_controller #(.TIMEOUT(TA)) u_dut_a (
    .inCLK(inCLK), .inRST(inRST), .iInReq(iInReq), .iOutReq(iOutReq),
    .iPortAddr(iPortAddr), .iAccData(iAccData),
    .iP1Ready(iP1Ready), .iP2Ready(iP2Ready), .iP1Data(iP1Data), .iP2Data(iP2Data),
    .iP3Busy(iP3Busy), .iP4Busy(iP4Busy),
    .oP1Ack(a_ack1), .oP2Ack(a_ack2), .oP3Data(a_p3), .oP4Data(a_p4),
    .oP3Strobe(a_stb3), .oP4Strobe(a_stb4), .oBusData(a_bus), .oLoadA(a_load),
    .oStall(a_stall), .oDone(a_done), .oErr(a_err)
  );

  io_port_controller #(.TIMEOUT(TB)) u_dut_b (
    .inCLK(inCLK), .inRST(inRST), .iInReq(iInReq), .iOutReq(iOutReq),
    .iPortAddr(iPortAddr), .iAccData(iAccData),
    .iP1Ready(iP1Ready), .iP2Ready(iP2Ready), .iP1Data(iP1Data), .iP2Data(iP2Data),
    .iP3Busy(iP3Busy), .iP4Busy(iP4Busy),
    .oP1Ack(b_ack1), .oP2Ack(b_ack2), .oP3Data(b_p3), .oP4Data(b_p4),
    .oP3Strobe(b_stb3), .oP4Strobe(b_stb4), .oBusData(b_bus), .oLoadA(b_load),
    .oStall(b_stall), .oDone(b_done), .oErr(b_err)
  );

  obs_t got [2];
  assign got[0] = {a_stall, a_load, a_ack1, a_ack2, a_stb3, a_stb4, a_done, a_err, a_bus, a_p3, a_p4};
  assign got[1] = {b_stall, b_load, b_ack1, b_ack2, b_stb3, b_stb4, b_done, b_err, b_bus, b_p3, b_p4};

  initial inCLK = 1'b0;
  always #5 inCLK = ~inCLK;

  // transaction description
  logic       t_in, t_out;
  logic [7:0] t_addr, t_acc, t_d1, t_d2;
  logic       rdy1 [MAXL];
  logic       rdy2 [MAXL];
  logic       bsy3 [MAXL];
  logic       bsy4 [MAXL];
  logic       xin  [MAXL];

  // reference model state
  obs_t       exp_o [2][MAXL];
  logic [7:0] m_bus [2];
  logic [7:0] m_p3  [2];
  logic [7:0] m_p4  [2];

  int n_checks, n_fail, txn_n;
  int obs_done [2];
  int obs_dcnt [2];
  int obs_err  [2];
  int obs_load [2];
  int obs_ack  [2];
  int obs_stb  [2];

  task automatic chk(input string name, input logic [31:0] g, input logic [31:0] e);
    n_checks++;
    if (g !== e) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, g, e);
    end
  endtask

  function automatic logic rdy(input logic sel2, input int c);
    return sel2 ? rdy2[c] : rdy1[c];
  endfunction

  function automatic logic bsy(input logic sel4, input int c);
    return sel4 ? bsy4[c] : bsy3[c];
  endfunction

  task automatic clear_stim();
    t_in = 0; t_out = 0; t_addr = 0; t_acc = 0; t_d1 = 0; t_d2 = 0;
    for (int c = 0; c < MAXL; c++) begin
      rdy1[c] = 0; rdy2[c] = 0; bsy3[c] = 0; bsy4[c] = 0; xin[c] = 0;
    end
  endtask

  // Expected outputs for every cycle of the transaction; cycle 0 = request.
  task automatic build_exp(input int d, input int T, output int done_c);
    int w, a, r;
    logic sel, abort, err;
    logic [7:0] byte_v;
    for (int c = 0; c < MAXL; c++) begin
      exp_o[d][c]     = '0;
      exp_o[d][c].bus = m_bus[d];
      exp_o[d][c].p3  = m_p3[d];
      exp_o[d][c].p4  = m_p4[d];
    end
    err = 0;
    done_c = 1;
    if (t_in && (t_addr == 8'h01 || t_addr == 8'h02)) begin
      sel = (t_addr == 8'h02);
      w = 0;
      for (int c = 1; c <= T; c++) if (w == 0 && rdy(sel, c)) w = c;
      abort  = (w == 0);
      a      = abort ? T + 1 : w + 1;
      byte_v = abort ? 8'h00 : (sel ? t_d2 : t_d1);
      for (int c = a; c < MAXL; c++) exp_o[d][c].bus = byte_v;
      exp_o[d][a].load = 1;
      if (sel) exp_o[d][a].ack2 = 1; else exp_o[d][a].ack1 = 1;
      if (abort) begin
        done_c = a + 1;
        err = 1;
      end else begin
        r = 0;
        for (int c = a + 1; c <= a + T; c++) if (r == 0 && !rdy(sel, c)) r = c;
        if (r == 0) begin done_c = a + T + 1; err = 1; end
        else done_c = r + 1;
        for (int c = a + 1; c < done_c; c++) begin
          if (sel) exp_o[d][c].ack2 = rdy(sel, c - 1);
          else     exp_o[d][c].ack1 = rdy(sel, c - 1);
        end
      end
      err = err | t_out;
      m_bus[d] = byte_v;
    end else if (t_in || !(t_addr == 8'h03 || t_addr == 8'h04)) begin
      done_c = 1;
      err = 1;
    end else begin
      sel = (t_addr == 8'h04);
      w = 0;
      for (int c = 1; c <= T; c++) if (w == 0 && !bsy(sel, c)) w = c;
      if (w == 0) begin
        done_c = T + 1;
        err = 1;
      end else begin
        if (sel) exp_o[d][w + 1].stb4 = 1; else exp_o[d][w + 1].stb3 = 1;
        for (int c = w + 1; c < MAXL; c++) begin
          if (sel) exp_o[d][c].p4 = t_acc; else exp_o[d][c].p3 = t_acc;
        end
        if (sel) m_p4[d] = t_acc; else m_p3[d] = t_acc;
        done_c = w + 2;
      end
    end
    for (int c = 0; c < done_c; c++) exp_o[d][c].stall = 1;
    exp_o[d][done_c].done = 1;
    exp_o[d][done_c].err  = err;
  endtask

  task automatic check_cycle(input int c);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("outputs dut%0d txn%0d cyc%0d", d, txn_n, c), got[d], exp_o[d][c]);
      if (got[d].done) begin
        obs_done[d] = c;
        obs_dcnt[d]++;
        obs_err[d] = int'(got[d].err);
      end
      obs_load[d] += int'(got[d].load);
      obs_ack[d]  += int'(got[d].ack1 | got[d].ack2);
      obs_stb[d]  += int'(got[d].stb3 | got[d].stb4);
    end
  endtask

  // Entered and left just after a rising edge. stop > 0 truncates the window.
  task automatic run_txn(input int stop);
    int da, db, len;
    build_exp(0, TA, da);
    build_exp(1, TB, db);
    len = ((da > db) ? da : db) + 2;
    if (stop > 0) len = stop;
    for (int d = 0; d < 2; d++) begin
      obs_done[d] = -1; obs_dcnt[d] = 0; obs_err[d] = 0;
      obs_load[d] = 0;  obs_ack[d]  = 0; obs_stb[d] = 0;
    end
    $display("txn %0d in=%0b out=%0b addr=%02h acc=%02h expected done cycle A=%0d B=%0d",
             txn_n, t_in, t_out, t_addr, t_acc, da, db);
    for (int c = 0; c < len; c++) begin
      iInReq    = (c == 0) ? t_in : xin[c];
      iOutReq   = (c == 0) ? t_out : 1'b0;
      iPortAddr = (c == 0) ? t_addr : 8'($urandom);
      iAccData  = (c == 0) ? t_acc : 8'($urandom);
      iP1Data   = t_d1;
      iP2Data   = t_d2;
      iP1Ready  = rdy1[c];
      iP2Ready  = rdy2[c];
      iP3Busy   = bsy3[c];
      iP4Busy   = bsy4[c];
      @(negedge inCLK);
      check_cycle(c);
      @(posedge inCLK);
      #1;
    end
    iInReq = 0; iOutReq = 0; iPortAddr = 0; iAccData = 0;
    iP1Ready = 0; iP2Ready = 0; iP3Busy = 0; iP4Busy = 0;
    txn_n++;
  endtask

  initial begin
    int k, dly, hold;
    n_checks = 0; n_fail = 0; txn_n = 0;
    for (int d = 0; d < 2; d++) begin m_bus[d] = 0; m_p3[d] = 0; m_p4[d] = 0; end
    inRST = 1; iInReq = 0; iOutReq = 0; iPortAddr = 0; iAccData = 0;
    iP1Data = 0; iP2Data = 0; iP1Ready = 0; iP2Ready = 0; iP3Busy = 0; iP4Busy = 0;
    clear_stim();
    repeat (2) @(posedge inCLK);
    #1;
    chk("reset_state_a", got[0], 32'h0);
    chk("reset_state_b", got[1], 32'h0);
    inRST = 0;
    @(posedge inCLK);
    #1;

    // IN 01h, ready drops during the ack cycle
    clear_stim(); t_in = 1; t_addr = 8'h01; t_d1 = 8'h5A;
    rdy1[0] = 1; rdy1[1] = 1;
    run_txn(0);
    chk("in01_done_cycle", 32'(obs_done[0]), 32'd4);
    chk("in01_ack_cycles", 32'(obs_ack[0]), 32'd1);
    chk("in01_loads", 32'(obs_load[0]), 32'd1);
    chk("in01_err", 32'(obs_err[0]), 32'd0);
    chk("in01_bus", {24'h0, a_bus}, 32'h5A);

    // OUT 04h, busy for 10 cycles
    clear_stim(); t_out = 1; t_addr = 8'h04; t_acc = 8'hC3;
    for (int c = 0; c <= 10; c++) bsy4[c] = 1;
    run_txn(0);
    chk("out04_p4", {24'h0, b_p4}, 32'hC3);
    chk("out04_p3", {24'h0, b_p3}, 32'h00);
    chk("out04_strobes", 32'(obs_stb[1]), 32'd1);
    chk("out04_done_cycle", 32'(obs_done[1]), 32'd13);
    chk("out04_short_timeout_err", 32'(obs_err[0]), 32'd1);
    chk("out04_short_timeout_p4", {24'h0, a_p4}, 32'h00);

    // IN 02h with ready stuck low
    clear_stim(); t_in = 1; t_addr = 8'h02; t_d2 = 8'h77;
    run_txn(0);
    chk("in02_tmo_done_cycle", 32'(obs_done[0]), 32'd10);
    chk("in02_tmo_err", 32'(obs_err[0]), 32'd1);
    chk("in02_tmo_load", 32'(obs_load[0]), 32'd1);
    chk("in02_tmo_bus", {24'h0, a_bus}, 32'h00);

    // IN from invalid port 07h
    clear_stim(); t_in = 1; t_addr = 8'h07;
    run_txn(0);
    chk("in07_done_cycle", 32'(obs_done[1]), 32'd1);
    chk("in07_err", 32'(obs_err[1]), 32'd1);
    chk("in07_loads", 32'(obs_load[1]), 32'd0);

    // simultaneous IN and OUT to port 01h
    clear_stim(); t_in = 1; t_out = 1; t_addr = 8'h01; t_d1 = 8'h3C; t_acc = 8'h99;
    for (int c = 0; c < 5; c++) rdy1[c] = 1;
    run_txn(0);
    chk("both_done_cycle", 32'(obs_done[0]), 32'd6);
    chk("both_err", 32'(obs_err[0]), 32'd1);
    chk("both_strobes", 32'(obs_stb[0]), 32'd0);

    // second IN request while in IN_REL
    clear_stim(); t_in = 1; t_addr = 8'h01; t_d1 = 8'hA5;
    for (int c = 0; c < 6; c++) rdy1[c] = 1;
    xin[3] = 1;
    run_txn(0);
    chk("inrel_done_count", 32'(obs_dcnt[0]), 32'd1);
    chk("inrel_done_count_b", 32'(obs_dcnt[1]), 32'd1);

    // reset during OUT_WAIT
    clear_stim(); t_out = 1; t_addr = 8'h03; t_acc = 8'h11;
    run_txn(0);
    chk("pre_reset_p3", {24'h0, b_p3}, 32'h11);
    clear_stim(); t_out = 1; t_addr = 8'h03; t_acc = 8'h55;
    for (int c = 0; c < MAXL; c++) bsy3[c] = 1;
    run_txn(4);
    inRST = 1;
    #1;
    chk("mid_reset_a", got[0], 32'h0);
    chk("mid_reset_b", got[1], 32'h0);
    for (int d = 0; d < 2; d++) begin m_bus[d] = 0; m_p3[d] = 0; m_p4[d] = 0; end
    @(posedge inCLK);
    #1;
    inRST = 0;
    clear_stim(); t_out = 1; t_addr = 8'h03; t_acc = 8'h22;
    run_txn(0);
    chk("post_reset_p3", {24'h0, a_p3}, 32'h22);
    chk("post_reset_err", 32'(obs_err[0]), 32'd0);

    // randomized transactions
    for (int n = 0; n < 40; n++) begin
      clear_stim();
      k = $urandom_range(0, 9);
      t_in  = (k <= 3) || (k == 8);
      t_out = (k >= 4);
      k = $urandom_range(0, 5);
      t_addr = (k <= 3) ? 8'(k + 1) : (k == 4) ? 8'h00 : 8'($urandom_range(5, 255));
      t_acc = 8'($urandom); t_d1 = 8'($urandom); t_d2 = 8'($urandom);
      for (int p = 0; p < 4; p++) begin
        dly  = $urandom_range(0, 12);
        hold = ($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(0, 12);
        for (int c = 0; c < MAXL; c++) begin
          case (p)
            0: rdy1[c] = (c >= dly) && (c < dly + hold);
            1: rdy2[c] = (c >= dly) && (c < dly + hold);
            2: bsy3[c] = (hold == 1000) || (c < dly);
            default: bsy4[c] = (hold == 1000) || (c < dly);
          endcase
        end
      end
      run_txn(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
